// File: rtl/word_serializer.sv
// Parallel-to-serial word converter: one active shifter plus a single pending
// slot, emitting MSB-first beats of SER_W bits with valid/ready on both sides.
module word_serializer #(
    parameter int DATA_W = 32,
    parameter int SER_W  = 4
) (
    input  logic              sysclk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [SER_W-1:0]  ser_data,
    output logic              ser_valid,
    input  logic              ser_ready,
    output logic              ser_last,
    output logic              busy
);

    localparam int BEATS = DATA_W / SER_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t              state, state_n;
    logic [DATA_W-1:0]   shreg, shreg_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic [DATA_W-1:0]   pend_word, pend_word_n;
    logic                pend_valid, pend_valid_n;

    logic                word_acc;
    logic                beat_acc;
    logic                last_beat;
    logic                last_acc;

    // Every output comes straight from a register, so the beat seen
    // downstream is always the top slice of the shifter.
    assign ser_valid = (state == SHIFT);
    assign ser_data  = shreg[DATA_W-1 -: SER_W];
    assign last_beat = (cnt == CNT_W'(BEATS - 1));
    assign ser_last  = ser_valid && last_beat;
    assign busy      = (state == SHIFT) || pend_valid;
    assign in_ready  = ~pend_valid;

    assign word_acc  = in_valid && in_ready;
    assign beat_acc  = ser_valid && ser_ready;
    assign last_acc  = beat_acc && last_beat;

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            shreg      <= '0;
            cnt        <= '0;
            pend_word  <= '0;
            pend_valid <= 1'b0;
        end else begin
            state      <= state_n;
            shreg      <= shreg_n;
            cnt        <= cnt_n;
            pend_word  <= pend_word_n;
            pend_valid <= pend_valid_n;
        end
    end

    // On the final beat the pending word wins over a fresh one; a fresh word
    // can only arrive then if the pending slot is empty, since in_ready is low
    // whenever it is full.
    always_comb begin
        state_n      = state;
        shreg_n      = shreg;
        cnt_n        = cnt;
        pend_word_n  = pend_word;
        pend_valid_n = pend_valid;

        case (state)
            IDLE: begin
                if (word_acc) begin
                    shreg_n = in_data;
                    cnt_n   = '0;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                if (last_acc) begin
                    cnt_n = '0;
                    if (pend_valid) begin
                        shreg_n      = pend_word;
                        pend_valid_n = 1'b0;
                    end else if (word_acc) begin
                        shreg_n = in_data;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    if (beat_acc) begin
                        shreg_n = shreg << SER_W;
                        cnt_n   = cnt + CNT_W'(1);
                    end
                    if (word_acc) begin
                        pend_word_n  = in_data;
                        pend_valid_n = 1'b1;
                    end
                end
            end
        endcase
    end

endmodule

// File: doc/word_serializer.md
WORD_SERIALIZER -- requirements
Module: word_serializer

Interface
REQ-001 Parameter DATA_W, default 32, parallel word width; SHALL be a multiple of SER_W.
REQ-002 Parameter SER_W, default 4, serial beat width; BEATS = DATA_W/SER_W (default 8).
REQ-003 sysclk  in  1  clock, all state SHALL update on the rising edge.
REQ-004 reset  in  1  reset, asynchronous, active-high.
REQ-005 in_data  in  DATA_W  parallel word offered by the writer.
REQ-006 in_valid  in  1  in_data valid.
REQ-007 in_ready  out  1  block can accept a word this cycle.
REQ-008 ser_data  out  SER_W  current serial beat, MSB-first slice of the word.
REQ-009 ser_valid  out  1  ser_data valid.
REQ-010 ser_ready  in  1  downstream accepts the beat.
REQ-011 ser_last  out  1  high on the final beat (index BEATS-1) of a word.
REQ-012 busy  out  1  high while the shifter or the pending register holds data.

Function
REQ-013 Storage: one shifter (word + beat counter, states IDLE/SHIFT) plus one pending register (word + pend_valid).
REQ-014 Word accept: in_valid & in_ready in the same cycle; in_ready SHALL equal ~pend_valid.
REQ-015 On accept, if the shifter is IDLE or its last beat is accepted in the same cycle, the word SHALL load the shifter directly; otherwise it SHALL load the pending register.
REQ-016 Beat accept: ser_valid & ser_ready; only a beat accept SHALL advance the counter.
REQ-017 ser_data and ser_valid SHALL be registered; a word accepted in cycle N SHALL present beat 0 in cycle N+1 when loaded directly.
REQ-018 Beat k SHALL be in_data[DATA_W-1-k*SER_W -: SER_W]; beat 0 = most significant slice.
REQ-019 With ser_valid high and ser_ready low, ser_data, ser_last and the counter SHALL hold unchanged.
REQ-020 On the last beat accept: if pend_valid, the pending word SHALL move to the shifter and pend_valid SHALL clear, with beat 0 the next cycle (no bubble); else if a new word is accepted that cycle, it SHALL load (REQ-015); else the shifter SHALL return to IDLE with ser_valid low.
REQ-021 The counter SHALL wrap BEATS-1 -> 0 on each word; with continuous ser_ready and in_valid, throughput SHALL be one beat per cycle with no idle gaps between words.
REQ-022 ser_last SHALL be high exactly when ser_valid and counter = BEATS-1.
REQ-023 busy = (state = SHIFT) | pend_valid.
REQ-024 in_data SHALL be sampled only at the accept edge; later changes SHALL NOT affect queued words.
REQ-025 A word accepted while pend_valid = 1 is impossible by construction; in_valid with in_ready low SHALL be ignored with no state change.

Reset
REQ-026 While reset is high: state IDLE, counter 0, pend_valid 0, ser_valid 0, ser_last 0, ser_data all zero, busy 0, in_ready 1.
REQ-027 Reset asserted mid-word SHALL discard the shifter and pending words; no partial beats SHALL appear after release.
REQ-028 First accept SHALL be possible on the first rising edge after reset deasserts.

Verification
REQ-029 Single word 0x12345678, ser_ready held 1 -> beats 1,2,3,4,5,6,7,8 on 8 consecutive cycles, ser_last on beat 8, then ser_valid 0, busy 0.
REQ-030 Back-to-back 0xDEADBEEF then 0xCAFEF00D, in_valid held -> 16 contiguous beats D,E,A,D,B,E,E,F,C,A,F,E,F,0,0,D with no gap, ser_last on beats 8 and 16.
REQ-031 ser_ready low for 3 cycles on beat 2 of 0xA5A5A5A5 -> ser_data holds 0xA for 3 cycles, counter unchanged, sequence then resumes correctly.
REQ-032 ser_ready held 0 and 2 words offered -> first word in shifter, second in pending, in_ready 0, third word refused until a last beat is accepted.
REQ-033 Reset pulsed at beat 4 with a pending word -> ser_valid 0, busy 0, in_ready 1 next cycle, no stale beats after release.
REQ-034 DATA_W=16, SER_W=8, word 0xBEEF -> beats 0xBE, 0xEF, ser_last on 0xEF.
